// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and sizing helpers for the ROM arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;

    localparam int CNT_W  = 2;
    localparam int STAT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester handshake, tagged response and ROM port bundle.
interface rom_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic [ADDR_WIDTH-1:0]       rom_addr;
    logic [DATA_WIDTH-1:0]       rom_q;
    logic                        busy;

    modport master (
        output req_valid, req_addr, rom_q,
        input  req_ready, rsp_valid, rsp_data, rom_addr, busy
    );

    modport slave (
        input  req_valid, req_addr, rom_q,
        output req_ready, rsp_valid, rsp_data, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select starting one past ptr.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx = IW'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous ROM, one access in flight.
// Optional per-requester grant counters under ROM_ARB_STATS_EN.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef ROM_ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0] grant_cnt,
`endif
    rom_arbiter_if.slave       bus
);
    localparam int IW = idx_w(N_REQ);

    state_e                state, nstate;
    logic [CNT_W-1:0]      cnt;
    logic [IW-1:0]         ptr, owner, idx;
    logic [N_REQ-1:0]      grant, ready, rsp_valid;
    logic                  any, accept;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rsp_data;

    rr_picker #(.N(N_REQ), .IW(IW)) picker (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    always_comb begin
        accept = (state == IDLE) && any;
        ready = accept ? grant : '0;
        nstate = (state == IDLE) ? (any ? WAIT : IDLE) :
                 (state == WAIT) ? ((cnt == CNT_W'(ROM_LATENCY - 1)) ? CAPTURE : WAIT) :
                 IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            ptr <= IW'(N_REQ - 1);
            owner <= '0;
            rom_addr <= '0;
            rsp_data <= '0;
            rsp_valid <= '0;
        end else begin
            state <= nstate;
            rsp_valid <= '0;
            if (accept) begin
                rom_addr <= bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                owner <= idx;
                ptr <= idx;
                cnt <= '0;
            end
            if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (state == CAPTURE) begin
                rsp_data <= bus.rom_q;
                rsp_valid <= N_REQ'(1) << owner;
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            if (!rst_n)
                grant_cnt[i*STAT_W +: STAT_W] <= '0;
            else if (ready[i] && grant_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + 1'b1;
    end
`endif

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data = rsp_data;
    assign bus.rom_addr = rom_addr;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized and directed scoreboard bench for rom_arbiter.
module tb_rom_arbiter;
    localparam int N = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LAT = 1;

    typedef struct {
        int           owner;
        logic [DW-1:0] data;
        int           due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    rom_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ROM_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ROM_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: odd multiplier keeps every address distinct.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] pipe [LAT];
    initial for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a * 37 + 91);

    always @(posedge clk) begin
        pipe[0] <= mem[bus.rom_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.rom_q = pipe[LAT-1];

    rsp_t sb [$];
    int   glog [$];
    int   last = N - 1;
    int   free_at = 0;
    int   gcnt [N];
    logic [N-1:0] acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last = N - 1;
        free_at = cyc;
        sb.delete();
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // One clock: predict the accept for the current inputs, then advance past the edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int w;
        @(negedge clk);
        exp_rdy = '0;
        w = -1;
        if (cyc >= free_at)
            for (int k = 1; k <= N; k++)
                if (w < 0 && bus.req_valid[(last + k) % N]) w = (last + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("busy", 32'(bus.busy), 32'(cyc < free_at));
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) glog.push_back(i);
        acc = exp_rdy;
        if (w >= 0) begin
            sb.push_back('{w, mem[bus.req_addr[w*AW +: AW]], cyc + LAT + 2});
            last = w;
            free_at = cyc + LAT + 2;
            if (gcnt[w] < 16'hFFFF) gcnt[w]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_drop();
        step();
        bus.req_valid = bus.req_valid & ~acc;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int t;
        t = 0;
        while (glog.size() < n && t < budget) begin
            step();
            t++;
        end
        if (glog.size() < n) check("grant_timeout", 32'(glog.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || cyc < free_at) && t < budget) begin
            step();
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    check("rsp_owner", 32'(bus.rsp_valid), 32'(1) << sb[0].owner);
                    check("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
                    check("rsp_cycle", 32'(cyc), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("rsp_missing", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;

        // single request from requester 2
        bus.req_addr[2*AW +: AW] = 8'h34;
        bus.req_valid[2] = 1'b1;
        glog.delete();
        wait_grants(1, 10);
        bus.req_valid = '0;
        if (glog.size() > 0) check("single_grant", 32'(glog[0]), 32'd2);
        wait_idle(20);

        // full contention from a fresh reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'(8'h10 + i);
        bus.req_valid = '1;
        glog.delete();
        wait_grants(8, 100);
        for (int i = 0; i < 8 && i < glog.size(); i++) check("contention_order", 32'(glog[i]), 32'(i % N));

        // wrap: last grant was 3, only 0 and 3 remain
        bus.req_valid = 4'b1001;
        glog.delete();
        wait_grants(2, 40);
        bus.req_valid = '0;
        if (glog.size() > 1) begin
            check("wrap_first", 32'(glog[0]), 32'd0);
            check("wrap_second", 32'(glog[1]), 32'd3);
        end
        wait_idle(20);

        // reset while waiting on the ROM
        bus.req_addr[0 +: AW] = 8'h55;
        bus.req_valid[0] = 1'b1;
        glog.delete();
        wait_grants(1, 10);
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("midop_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("midop_busy", 32'(bus.busy), 32'd0);
        check("midop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1001;
        glog.delete();
        wait_grants(1, 10);
        bus.req_valid = '0;
        if (glog.size() > 0) check("post_reset_first", 32'(glog[0]), 32'd0);

        // withdrawn while arbiter busy: must never be answered
        bus.req_addr[1*AW +: AW] = 8'h77;
        bus.req_valid[1] = 1'b1;
        bus.req_valid[1] = 1'b0;
        step();
        wait_idle(20);

        // randomized traffic with occasional withdrawal
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && !acc[i]) begin
                    if ($urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i] = ($urandom_range(2) == 0);
                    bus.req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        bus.req_valid = '0;
        wait_idle(40);

`ifdef ROM_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(gcnt[i]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
